// File: rtl/vco_demod.sv
// Hysteresis-qualified period demodulator: recovers a control code from
// the averaged period of a sampled oscillator waveform.
module vco_demod #(
    parameter int HI_TH    = 144,
    parameter int LO_TH    = 112,
    parameter int AVG_LOG2 = 2,
    parameter int P_MAX    = 200,
    parameter int TIMEOUT  = 1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  v_in,
    output logic [7:0]  v_out,
    output logic [15:0] period,
    output logic        valid,
    output logic        lost
);
    localparam int AW = 16 + AVG_LOG2;
    localparam int WW = AVG_LOG2 + 1;

    typedef enum logic [1:0] {IDLE, LOW, HIGH} state_e;

    state_e          state_q, state_d;
    logic [15:0]     cnt_q, cnt_d;
    logic [AW-1:0]   acc_q, acc_d;
    logic [WW-1:0]   wcnt_q, wcnt_d;
    logic            armed_q, armed_d;
    logic [7:0]      vout_q, vout_d;
    logic [15:0]     period_q, period_d;
    logic            valid_q, valid_d;
    logic            lost_q, lost_d;

    logic            is_hi, is_lo, rise, tmo, win_done;
    logic [15:0]     meas, avg;
    logic [AW-1:0]   acc_sum, acc_shr;
    logic [16:0]     diff;
    logic [7:0]      code;

    assign is_hi    = v_in >= 8'(HI_TH);
    assign is_lo    = v_in <= 8'(LO_TH);
    assign rise     = (state_q == LOW) && is_hi;
    assign tmo      = !rise && (cnt_q == 16'(TIMEOUT));
    assign meas     = cnt_q + 16'd1;
    assign acc_sum  = acc_q + AW'(meas);
    assign acc_shr  = acc_sum >> AVG_LOG2;
    assign avg      = acc_shr[15:0];
    assign win_done = wcnt_q == WW'((1 << AVG_LOG2) - 1);
    assign diff     = 17'(P_MAX) - {1'b0, avg};

    // Long periods pin the code at 0; short ones saturate at full scale.
    always_comb begin
        code = 8'd0;
        if ({1'b0, avg} < 17'(P_MAX))
            code = (diff > 17'd255) ? 8'hFF : diff[7:0];
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = rise ? 16'd0 : ((cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1);
        acc_d    = acc_q;
        wcnt_d   = wcnt_q;
        armed_d  = armed_q;
        vout_d   = vout_q;
        period_d = period_q;
        valid_d  = 1'b0;
        lost_d   = lost_q;

        unique case (state_q)
            IDLE: begin
                if (is_lo)      state_d = LOW;
                else if (is_hi) state_d = HIGH;
            end
            LOW:  if (is_hi) state_d = HIGH;
            HIGH: if (is_lo) state_d = LOW;
            default: state_d = IDLE;
        endcase

        if (rise) begin
            armed_d = 1'b1;
            if (armed_q) begin
                if (win_done) begin
                    period_d = avg;
                    vout_d   = code;
                    valid_d  = 1'b1;
                    lost_d   = 1'b0;
                    acc_d    = '0;
                    wcnt_d   = '0;
                end else begin
                    acc_d  = acc_sum;
                    wcnt_d = wcnt_q + WW'(1);
                end
            end
        end else if (tmo) begin
            // Lock lost: drop the partial window and re-qualify from scratch.
            state_d = IDLE;
            lost_d  = 1'b1;
            vout_d  = 8'd0;
            acc_d   = '0;
            wcnt_d  = '0;
            armed_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            wcnt_q   <= '0;
            armed_q  <= 1'b0;
            vout_q   <= '0;
            period_q <= '0;
            valid_q  <= 1'b0;
            lost_q   <= 1'b1;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            wcnt_q   <= wcnt_d;
            armed_q  <= armed_d;
            vout_q   <= vout_d;
            period_q <= period_d;
            valid_q  <= valid_d;
            lost_q   <= lost_d;
        end
    end

    assign v_out  = vout_q;
    assign period = period_q;
    assign valid  = valid_q;
    assign lost   = lost_q;
endmodule
